addr_gen_fft_iter: RTL and testbench
====================================

// Module: addr_gen_fft_iter
// PURPOSE
//  Address generator for the iterative radix-2 DIT FFT datapath. Sits directly downstream of the iterative
//  FFT control unit and consumes its BUT_STROB / ADDR_EN pulses. Produces in-place RAM read-pair,
//  write-pair and twiddle-ROM addresses for every butterfly of every layer.
// PARAMETERS
//  LAYERS       5   FFT stages, log2(N); N = 2*BUTTERFLYES
//  BUTTERFLYES  16  butterflies per layer, = N/2
//  LayWL        3   layer counter width, >= clog2(LAYERS)
//  ButtWL       4   butterfly counter width = log2(BUTTERFLYES); address width AddrWL = ButtWL+1
// PORTS
//  CLK        in   1        clock, rising edge
//  RST_N      in   1        asynchronous active-low reset
//  EN         in   1        clock enable; low = every register holds
//  START      in   1        begin a new transform
//  BUT_STROB  in   1        operands of current pair latched; advance to next pair
//  ADDR_EN    in   1        write of the pair held on WR_* occurs this cycle
//  RD_ADDR_A  out  AddrWL   read address, upper-leg input
//  RD_ADDR_B  out  AddrWL   read address, lower-leg input
//  WR_ADDR_A  out  AddrWL   write address, upper-leg result
//  WR_ADDR_B  out  AddrWL   write address, lower-leg result
//  TW_ADDR    out  ButtWL   twiddle index for the pair on WR_*
//  LAYER      out  LayWL    layer of the pair on RD_*
//  BUSY       out  1        transform in progress
//  DONE       out  1        one-cycle pulse after final write
// BEHAVIOUR
//  - All outputs registered; reset value 0 for all. Every register except reset updates only when EN=1.
//  - Pair map, layer l, butterfly b: j = b mod 2^l, g = b >> l; A = (g << (l+1)) | j; B = A + 2^l;
//    TW = j << (LAYERS-1-l). All arithmetic truncated to AddrWL / ButtWL, no carries out.
//  - FSM IDLE / RUN / DRAIN, reset -> IDLE.
//  - IDLE: START -> RUN; b=0, l=0; RD_* = pair (0,0); BUSY=1 the cycle after START.
//  - RUN, BUT_STROB: WR_* <= RD_*, TW_ADDR <= TW(l,b); counters advance.
//    - b == BUTTERFLYES-1 wraps b to 0 and increments l.
//    - RD_*/LAYER show the new pair one cycle after the strobe.
//    - Strobe on last pair (l=LAYERS-1, b=BUTTERFLYES-1) -> DRAIN; RD_* hold.
//  - RUN, ADDR_EN: no state change; WR_* and TW_ADDR hold until the next BUT_STROB.
//  - DRAIN, ADDR_EN: -> IDLE; DONE=1 for one cycle; BUSY=0 in that same cycle. BUT_STROB in DRAIN ignored.
//  - BUT_STROB/ADDR_EN in IDLE ignored. BUT_STROB and ADDR_EN in the same cycle: both honoured,
//    ADDR_EN refers to the WR_* value before the update.
//  - START in RUN/DRAIN restarts at pair (0,0); no DONE. START wins over a simultaneous strobe.
//  - RST_N low mid-transform: immediate return to IDLE with all outputs 0.
// CONFIGURATION
//  - BITREV_INPUT_EN defined: layer-0 RD_*/WR_* addresses are bit-reversed over AddrWL bits.
//    Input buffer holds natural order. TW_ADDR is unaffected.
//  - Undefined: no reversal; input buffer holds bit-reversed order (written by the loader).
// STRUCTURE
//  - Package fft_iter_pkg: FSM state encoding (IDLE=2'b00, RUN=2'b01, DRAIN=2'b10),
//    function addr_wl(ButtWL), function bitrev(x, width).
//  - Sub-module fft_pair_map (combinational): (l, b) -> (A, B, TW). Instanced once for the next pair.
//  - Counters, FSM and output registers live in the top module.
// TESTING (N=32, defaults)
//  - Reset, then START: RD_A=0, RD_B=1, LAYER=0, BUSY=1, DONE=0.
//  - One BUT_STROB from (0,0): WR_A=0, WR_B=1, TW=0; next cycle RD_A=2, RD_B=3.
//  - Run to layer 1: b=0 gives RD (0,2); b=1 gives RD (1,3), then TW=8 after its strobe.
//    Layer 4, b=3: RD (3,19), TW=3.
//  - Full run of 80 strobe/ADDR_EN pairs: DONE exactly once, on the 80th ADDR_EN + 1 cycle; BUSY=0 after.
//    Extra BUT_STROB in DRAIN leaves RD/WR unchanged.
//  - EN=0 for 5 cycles with strobes mid-run: no output changes. START mid-layer 2: back to RD (0,1), no DONE.
//  - BITREV_INPUT_EN build: layer 0, b=1 gives RD (8,24); layer 1 unchanged vs default build.

Source files
------------

// File: rtl/addr_gen_fft_iter_pkg.sv
// fft_iter_pkg: shared FSM encoding and helpers for the iterative FFT address generator
//   state_t  : IDLE / RUN / DRAIN controller states
//   addr_wl  : RAM address width for a given butterfly-counter width
//   bitrev   : reverse the low 'width' bits of x
package fft_iter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } state_t;

    function automatic int addr_wl(input int butt_wl);
        return butt_wl + 1;
    endfunction

    function automatic logic [31:0] bitrev(input logic [31:0] x, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < width; i++) r[i] = x[width-1-i];
        return r;
    endfunction

endpackage

// File: rtl/addr_gen_fft_iter_if.sv
// addr_gen_fft_iter_if: control-in / address-out bundle between FFT control unit and address generator
//   en, start, but_strob, addr_en            : control from the FFT control unit (master drives)
//   rd_addr_a/b, wr_addr_a/b, tw_addr, layer : addresses produced by the generator (slave drives)
//   busy, done                               : transform status
interface addr_gen_fft_iter_if #(
    parameter int LayWL  = 3,
    parameter int ButtWL = 4
);
    localparam int AddrWL = ButtWL + 1;

    logic              en;
    logic              start;
    logic              but_strob;
    logic              addr_en;
    logic [AddrWL-1:0] rd_addr_a;
    logic [AddrWL-1:0] rd_addr_b;
    logic [AddrWL-1:0] wr_addr_a;
    logic [AddrWL-1:0] wr_addr_b;
    logic [ButtWL-1:0] tw_addr;
    logic [LayWL-1:0]  layer;
    logic              busy;
    logic              done;

    modport master (
        output en, start, but_strob, addr_en,
        input  rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, tw_addr, layer, busy, done
    );

    modport slave (
        input  en, start, but_strob, addr_en,
        output rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, tw_addr, layer, busy, done
    );

endinterface

// File: rtl/addr_gen_fft_iter_pair_map.sv
// fft_pair_map: combinational (layer, butterfly) -> in-place pair addresses and twiddle index
//   l  : layer index
//   b  : butterfly index within the layer
//   a  : upper-leg address  (g << (l+1)) | j
//   bo : lower-leg address  a + 2^l
//   tw : twiddle index      j << (LAYERS-1-l)
module fft_pair_map
    import fft_iter_pkg::*;
#(
    parameter int LAYERS = 5,
    parameter int LayWL  = 3,
    parameter int ButtWL = 4
) (
    input  logic [LayWL-1:0]            l,
    input  logic [ButtWL-1:0]           b,
    output logic [addr_wl(ButtWL)-1:0]  a,
    output logic [addr_wl(ButtWL)-1:0]  bo,
    output logic [ButtWL-1:0]           tw
);
    localparam int AddrWL = addr_wl(ButtWL);

    logic [AddrWL-1:0] bx, j, g;

    assign bx = {1'b0, b};
    assign j  = bx & ((AddrWL'(1) << l) - AddrWL'(1));
    assign g  = bx >> l;
    assign a  = ((g << l) << 1) | j;
    assign bo = a + (AddrWL'(1) << l);
    assign tw = ButtWL'(j << (LAYERS - 1 - int'(l)));

endmodule

// File: rtl/addr_gen_fft_iter.sv
// addr_gen_fft_iter: read/write/twiddle address generator for an iterative radix-2 DIT FFT
//   CLK   : clock, rising edge
//   RST_N : asynchronous active-low reset, clears every register
//   bus   : addr_gen_fft_iter_if.slave (en/start/but_strob/addr_en in; addresses, busy, done out)
//   Macro BITREV_INPUT_EN: layer-0 RAM addresses are bit-reversed so the input buffer holds natural order.
module addr_gen_fft_iter
    import fft_iter_pkg::*;
#(
    parameter int LAYERS      = 5,
    parameter int BUTTERFLYES = 16,
    parameter int LayWL       = 3,
    parameter int ButtWL      = 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    addr_gen_fft_iter_if.slave  bus
);
    localparam int AddrWL = addr_wl(ButtWL);

    state_t            state, state_n;
    logic [ButtWL-1:0] b, map_b, map_tw, tw_rd, tw;
    logic [LayWL-1:0]  l, map_l, layer;
    logic [AddrWL-1:0] map_a, map_bo, nxt_a, nxt_b, rd_a, rd_b, wr_a, wr_b;
    logic              last_b, last, restart, step, finish, busy, done;

    assign last_b = b == ButtWL'(BUTTERFLYES - 1);
    assign last   = last_b && l == LayWL'(LAYERS - 1);

    // Map is evaluated for the pair that RD_* will show next
    assign map_b = (restart || last_b) ? '0 : b + 1'b1;
    assign map_l = restart ? '0 : last_b ? l + 1'b1 : l;

    fft_pair_map #(.LAYERS(LAYERS), .LayWL(LayWL), .ButtWL(ButtWL)) u_map (
        .l  (map_l),
        .b  (map_b),
        .a  (map_a),
        .bo (map_bo),
        .tw (map_tw)
    );

`ifdef BITREV_INPUT_EN
    assign nxt_a = (map_l == '0) ? AddrWL'(bitrev(32'(map_a), AddrWL)) : map_a;
    assign nxt_b = (map_l == '0) ? AddrWL'(bitrev(32'(map_bo), AddrWL)) : map_bo;
`else
    assign nxt_a = map_a;
    assign nxt_b = map_bo;
`endif

    // START overrides everything else, including a strobe in the same cycle
    always_comb begin
        state_n = state;
        restart = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        if (bus.start) begin
            state_n = RUN;
            restart = 1'b1;
        end else if (state == RUN && bus.but_strob) begin
            step    = 1'b1;
            state_n = last ? DRAIN : RUN;
        end else if (state == DRAIN && bus.addr_en) begin
            finish  = 1'b1;
            state_n = IDLE;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else if (bus.en) state <= state_n;
    end

    // tw_rd carries the twiddle of the pair on RD_* so it can follow the pair onto WR_*
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            b     <= '0;
            l     <= '0;
            rd_a  <= '0;
            rd_b  <= '0;
            layer <= '0;
            tw_rd <= '0;
            wr_a  <= '0;
            wr_b  <= '0;
            tw    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (bus.en) begin
            done <= finish;
            busy <= restart ? 1'b1 : finish ? 1'b0 : busy;
            if (restart || (step && !last)) begin
                b     <= map_b;
                l     <= map_l;
                rd_a  <= nxt_a;
                rd_b  <= nxt_b;
                layer <= map_l;
                tw_rd <= map_tw;
            end
            if (step) begin
                wr_a <= rd_a;
                wr_b <= rd_b;
                tw   <= tw_rd;
            end
        end
    end

    assign bus.rd_addr_a = rd_a;
    assign bus.rd_addr_b = rd_b;
    assign bus.wr_addr_a = wr_a;
    assign bus.wr_addr_b = wr_b;
    assign bus.tw_addr   = tw;
    assign bus.layer     = layer;
    assign bus.busy      = busy;
    assign bus.done      = done;

endmodule

// File: tb/tb_addr_gen_fft_iter.sv
// tb_addr_gen_fft_iter: directed self-checking bench for addr_gen_fft_iter (N=32 defaults)
module tb_addr_gen_fft_iter;

`ifdef BITREV_INPUT_EN
    localparam int B00 = 16;
    localparam int A01 = 8;
    localparam int B01 = 24;
`else
    localparam int B00 = 1;
    localparam int A01 = 2;
    localparam int B01 = 3;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    addr_gen_fft_iter_if bus ();

    addr_gen_fft_iter dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic step_pair();
        bus.but_strob = 1'b1;
        cyc();
        bus.but_strob = 1'b0;
        bus.addr_en = 1'b1;
        cyc();
        bus.addr_en = 1'b0;
    endtask

    task automatic step_pairs(input int n);
        for (int i = 0; i < n; i++) step_pair();
    endtask

    initial begin
        bus.en = 1'b1;
        bus.start = 1'b0;
        bus.but_strob = 1'b0;
        bus.addr_en = 1'b0;
        cyc();
        cyc();
        chk("rst_rd_a", 32'(bus.rd_addr_a), 0);
        chk("rst_rd_b", 32'(bus.rd_addr_b), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        rst_n = 1'b1;
        cyc();
        bus.addr_en = 1'b1;
        bus.but_strob = 1'b1;
        cyc();
        bus.addr_en = 1'b0;
        bus.but_strob = 1'b0;
        chk("idle_ignore_busy", 32'(bus.busy), 0);
        chk("idle_ignore_wr_b", 32'(bus.wr_addr_b), 0);

        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        chk("start_rd_a", 32'(bus.rd_addr_a), 0);
        chk("start_rd_b", 32'(bus.rd_addr_b), B00);
        chk("start_layer", 32'(bus.layer), 0);
        chk("start_busy", 32'(bus.busy), 1);
        chk("start_done", 32'(bus.done), 0);

        bus.but_strob = 1'b1;
        cyc();
        bus.but_strob = 1'b0;
        chk("s1_wr_a", 32'(bus.wr_addr_a), 0);
        chk("s1_wr_b", 32'(bus.wr_addr_b), B00);
        chk("s1_tw", 32'(bus.tw_addr), 0);
        chk("s1_rd_a", 32'(bus.rd_addr_a), A01);
        chk("s1_rd_b", 32'(bus.rd_addr_b), B01);
        bus.addr_en = 1'b1;
        cyc();
        bus.addr_en = 1'b0;
        chk("aen_wr_a_hold", 32'(bus.wr_addr_a), 0);
        chk("aen_rd_a_hold", 32'(bus.rd_addr_a), A01);

        step_pairs(15);
        chk("l1b0_rd_a", 32'(bus.rd_addr_a), 0);
        chk("l1b0_rd_b", 32'(bus.rd_addr_b), 2);
        chk("l1b0_layer", 32'(bus.layer), 1);
        chk("l1b0_wr_b", 32'(bus.wr_addr_b), 31);
        step_pair();
        chk("l1b1_rd_a", 32'(bus.rd_addr_a), 1);
        chk("l1b1_rd_b", 32'(bus.rd_addr_b), 3);
        chk("l1b0_tw", 32'(bus.tw_addr), 0);
        step_pair();
        chk("l1b1_tw", 32'(bus.tw_addr), 8);
        chk("l1b1_wr_a", 32'(bus.wr_addr_a), 1);
        chk("l1b1_wr_b", 32'(bus.wr_addr_b), 3);
        chk("l1b2_rd_a", 32'(bus.rd_addr_a), 4);
        chk("l1b2_rd_b", 32'(bus.rd_addr_b), 6);

        bus.en = 1'b0;
        bus.but_strob = 1'b1;
        bus.addr_en = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        bus.but_strob = 1'b0;
        bus.addr_en = 1'b0;
        bus.en = 1'b1;
        chk("en0_rd_a", 32'(bus.rd_addr_a), 4);
        chk("en0_rd_b", 32'(bus.rd_addr_b), 6);
        chk("en0_wr_a", 32'(bus.wr_addr_a), 1);
        chk("en0_tw", 32'(bus.tw_addr), 8);
        chk("en0_layer", 32'(bus.layer), 1);

        step_pairs(49);
        chk("l4b3_rd_a", 32'(bus.rd_addr_a), 3);
        chk("l4b3_rd_b", 32'(bus.rd_addr_b), 19);
        chk("l4b3_layer", 32'(bus.layer), 4);
        step_pair();
        chk("l4b3_tw", 32'(bus.tw_addr), 3);
        chk("l4b3_wr_b", 32'(bus.wr_addr_b), 19);

        step_pairs(11);
        bus.but_strob = 1'b1;
        cyc();
        bus.but_strob = 1'b0;
        chk("last_wr_a", 32'(bus.wr_addr_a), 15);
        chk("last_wr_b", 32'(bus.wr_addr_b), 31);
        chk("last_tw", 32'(bus.tw_addr), 15);
        chk("last_rd_b", 32'(bus.rd_addr_b), 31);
        chk("drain_busy", 32'(bus.busy), 1);
        bus.but_strob = 1'b1;
        cyc();
        bus.but_strob = 1'b0;
        chk("drain_strob_rd_a", 32'(bus.rd_addr_a), 15);
        chk("drain_strob_wr_a", 32'(bus.wr_addr_a), 15);
        chk("drain_strob_done", 32'(bus.done), 0);
        chk("done_cnt_pre", 32'(done_cnt), 0);
        bus.addr_en = 1'b1;
        cyc();
        bus.addr_en = 1'b0;
        chk("final_done", 32'(bus.done), 1);
        chk("final_busy", 32'(bus.busy), 0);
        cyc();
        chk("post_done", 32'(bus.done), 0);
        chk("post_busy", 32'(bus.busy), 0);
        chk("done_cnt", 32'(done_cnt), 1);
        step_pair();
        chk("idle2_wr_a", 32'(bus.wr_addr_a), 15);
        chk("idle2_busy", 32'(bus.busy), 0);

        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        step_pairs(37);
        chk("l2_layer", 32'(bus.layer), 2);
        bus.start = 1'b1;
        bus.but_strob = 1'b1;
        cyc();
        bus.start = 1'b0;
        bus.but_strob = 1'b0;
        chk("restart_rd_a", 32'(bus.rd_addr_a), 0);
        chk("restart_rd_b", 32'(bus.rd_addr_b), B00);
        chk("restart_layer", 32'(bus.layer), 0);
        chk("restart_busy", 32'(bus.busy), 1);
        cyc();
        chk("restart_done_cnt", 32'(done_cnt), 1);

        step_pair();
        rst_n = 1'b0;
        #2;
        chk("arst_rd_a", 32'(bus.rd_addr_a), 0);
        chk("arst_rd_b", 32'(bus.rd_addr_b), 0);
        chk("arst_wr_b", 32'(bus.wr_addr_b), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
